// File: rtl/quad_encoder_bank.sv
// Bank of NUM_CH rotary-encoder channels. Each channel has debounced a/b inputs, an x1/x4
// quadrature decoder, a wrap/saturate counter with preload, step/dir strobes and a sticky error flag.
module quad_encoder_bank #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned HIST_LEN = 8,
  parameter int unsigned STEP     = 1,
  parameter int unsigned DECODE   = 1,
  parameter int unsigned SATURATE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       a,
  input  logic [NUM_CH-1:0]       b,
  input  logic [NUM_CH-1:0]       load,
  input  logic [WIDTH-1:0]        load_value,
  input  logic                    clr_err,
  output logic [NUM_CH*WIDTH-1:0] value,
  output logic [NUM_CH-1:0]       step,
  output logic [NUM_CH-1:0]       dir,
  output logic [NUM_CH-1:0]       err
);

  localparam logic [WIDTH:0] StepInc = (WIDTH+1)'(STEP);
  localparam bit             X4Mode  = (DECODE == 4);
  localparam bit             Clamp   = (SATURATE != 0);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [HIST_LEN-1:0] hist_a_q, hist_b_q;
    logic                deb_a_q, deb_b_q;
    logic                deb_a_d, deb_b_d;
    logic [1:0]          prev_q;
    logic [1:0]          cur_ab;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                step_q, step_d;
    logic                dir_q, dir_d;
    logic                err_q, err_d;
    logic                is_step, is_up, illegal;
    logic [WIDTH:0]      sum, diff;

    // Debounced bit moves only once the whole history agrees; otherwise it holds.
    always_comb begin
      deb_a_d = deb_a_q;
      if (&hist_a_q) begin
        deb_a_d = 1'b1;
      end else if (hist_a_q == '0) begin
        deb_a_d = 1'b0;
      end
      deb_b_d = deb_b_q;
      if (&hist_b_q) begin
        deb_b_d = 1'b1;
      end else if (hist_b_q == '0) begin
        deb_b_d = 1'b0;
      end
    end

    always_comb begin
      cur_ab  = {deb_a_q, deb_b_q};
      is_step = 1'b0;
      is_up   = 1'b0;
      illegal = 1'b0;
      if (X4Mode) begin
        // {prev, cur}: forward Gray order is 00 -> 01 -> 11 -> 10 -> 00.
        unique case ({prev_q, cur_ab})
          4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
            is_step = 1'b1;
            is_up   = 1'b1;
          end
          4'b0100, 4'b1101, 4'b1011, 4'b0010: begin
            is_step = 1'b1;
          end
          4'b0011, 4'b1100, 4'b0110, 4'b1001: begin
            illegal = 1'b1;
          end
          default: ;
        endcase
      end else begin
        is_step = ~prev_q[1] & cur_ab[1];
        is_up   = ~cur_ab[0];
      end
    end

    always_comb begin
      sum    = {1'b0, cnt_q} + StepInc;
      diff   = {1'b0, cnt_q} - StepInc;
      cnt_d  = cnt_q;
      step_d = is_step;
      dir_d  = dir_q;
      err_d  = illegal | (err_q & ~clr_err);
      if (is_step) begin
        dir_d = is_up;
        if (is_up) begin
          cnt_d = (Clamp && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
        end else begin
          cnt_d = (Clamp && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
        end
      end
      // Preload wins over a concurrent step; the strobe still reports the step.
      if (load[i]) begin
        cnt_d = load_value;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hist_a_q <= '0;
        hist_b_q <= '0;
        deb_a_q  <= 1'b0;
        deb_b_q  <= 1'b0;
        prev_q   <= 2'b00;
        cnt_q    <= '0;
        step_q   <= 1'b0;
        dir_q    <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        hist_a_q <= {hist_a_q[HIST_LEN-2:0], a[i]};
        hist_b_q <= {hist_b_q[HIST_LEN-2:0], b[i]};
        deb_a_q  <= deb_a_d;
        deb_b_q  <= deb_b_d;
        prev_q   <= cur_ab;
        cnt_q    <= cnt_d;
        step_q   <= step_d;
        dir_q    <= dir_d;
        err_q    <= err_d;
      end
    end

    assign value[i*WIDTH +: WIDTH] = cnt_q;
    assign step[i]                 = step_q;
    assign dir[i]                  = dir_q;
    assign err[i]                  = err_q;
  end

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Drives three encoder-bank configurations from shared stimulus and compares every output,
// every cycle, against a run-length debounce / Gray-position reference model.
module tb_quad_encoder_bank;

  localparam int NI = 3;
  localparam int NC = 2;
  localparam int H  = 8;
  localparam int DEC_P [NI] = '{1, 1, 4};
  localparam int SAT_P [NI] = '{0, 1, 0};
  localparam int STP_P [NI] = '{1, 4, 1};

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] a, b, load;
  logic [7:0]    load_value;
  logic          clr_err;
  logic [15:0]   val   [NI];
  logic [NC-1:0] stp_o [NI];
  logic [NC-1:0] dir_o [NI];
  logic [NC-1:0] err_o [NI];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: shared debounce per channel, decode/counter per instance and channel.
  bit last_a [NC], last_b [NC];
  int run_a [NC], run_b [NC];
  bit deb_a [NC], deb_b [NC], prv_a [NC], prv_b [NC];
  int mv [NI][NC];
  bit ms [NI][NC], md [NI][NC], me [NI][NC];
  int gp [NC], hold_cnt [NC];

  always #5 clk = ~clk;

  quad_encoder_bank #(.NUM_CH(NC), .WIDTH(8), .HIST_LEN(H), .STEP(1), .DECODE(1), .SATURATE(0))
    u_x1 (.clk(clk), .reset(reset), .a(a), .b(b), .load(load), .load_value(load_value),
          .clr_err(clr_err), .value(val[0]), .step(stp_o[0]), .dir(dir_o[0]), .err(err_o[0]));
  quad_encoder_bank #(.NUM_CH(NC), .WIDTH(8), .HIST_LEN(H), .STEP(4), .DECODE(1), .SATURATE(1))
    u_sat (.clk(clk), .reset(reset), .a(a), .b(b), .load(load), .load_value(load_value),
           .clr_err(clr_err), .value(val[1]), .step(stp_o[1]), .dir(dir_o[1]), .err(err_o[1]));
  quad_encoder_bank #(.NUM_CH(NC), .WIDTH(8), .HIST_LEN(H), .STEP(1), .DECODE(4), .SATURATE(0))
    u_x4 (.clk(clk), .reset(reset), .a(a), .b(b), .load(load), .load_value(load_value),
          .clr_err(clr_err), .value(val[2]), .step(stp_o[2]), .dir(dir_o[2]), .err(err_o[2]));

  function automatic int gpos(bit av, bit bv);
    case ({av, bv})
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      last_a[c] = 0; last_b[c] = 0; run_a[c] = H; run_b[c] = H;
      deb_a[c] = 0; deb_b[c] = 0; prv_a[c] = 0; prv_b[c] = 0;
      for (int i = 0; i < NI; i++) begin
        mv[i][c] = 0; ms[i][c] = 0; md[i][c] = 0; me[i][c] = 0;
      end
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NC; c++) begin
      for (int i = 0; i < NI; i++) begin
        bit st, up, bad;
        int d, nv;
        st = 0; up = 0; bad = 0;
        if (DEC_P[i] == 1) begin
          if (!prv_a[c] && deb_a[c]) begin st = 1; up = !deb_b[c]; end
        end else begin
          d = (gpos(deb_a[c], deb_b[c]) - gpos(prv_a[c], prv_b[c]) + 4) % 4;
          if (d == 1) begin st = 1; up = 1; end
          else if (d == 3) st = 1;
          else if (d == 2) bad = 1;
        end
        nv = mv[i][c];
        if (st) nv = up ? nv + STP_P[i] : nv - STP_P[i];
        if (SAT_P[i] != 0) nv = (nv > 255) ? 255 : (nv < 0) ? 0 : nv;
        else nv = nv & 255;
        if (load[c]) nv = load_value;
        mv[i][c] = nv;
        ms[i][c] = st;
        if (st) md[i][c] = up;
        me[i][c] = bad | (me[i][c] & !clr_err);
      end
      prv_a[c] = deb_a[c];
      prv_b[c] = deb_b[c];
      // A level is accepted once it has been sampled H times in a row.
      if (run_a[c] >= H) deb_a[c] = last_a[c];
      if (run_b[c] >= H) deb_b[c] = last_b[c];
      if (a[c] == last_a[c]) run_a[c] = (run_a[c] < H) ? run_a[c] + 1 : H;
      else begin last_a[c] = a[c]; run_a[c] = 1; end
      if (b[c] == last_b[c]) run_b[c] = (run_b[c] < H) ? run_b[c] + 1 : H;
      else begin last_b[c] = b[c]; run_b[c] = 1; end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < NC; c++) begin
        check($sformatf("value i%0d c%0d", i, c), 32'(val[i][c*8 +: 8]), 32'(mv[i][c]));
        check($sformatf("step i%0d c%0d", i, c), 32'(stp_o[i][c]), 32'(ms[i][c]));
        check($sformatf("dir i%0d c%0d", i, c), 32'(dir_o[i][c]), 32'(md[i][c]));
        check($sformatf("err i%0d c%0d", i, c), 32'(err_o[i][c]), 32'(me[i][c]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    model_reset();
    #1 compare_all();
    #1 reset = 1'b0;
  endtask

  task automatic set_ab(input int c, input bit av, input bit bv, input int n);
    a[c] = av;
    b[c] = bv;
    ticks(n);
  endtask

  initial begin
    a = '0; b = '0; load = '0; load_value = '0; clr_err = 1'b0;
    reset = 1'b1;
    model_reset();
    #12;
    compare_all();
    reset = 1'b0;
    ticks(3);
    pulse_reset();

    // First step: exactly H+2 edges from the raw edge.
    a[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 9) check("first_step_early", 32'(val[0][7:0]), 32'd0);
    end
    check("first_step_value", 32'(val[0][7:0]), 32'd1);
    check("first_step_strobe", 32'(stp_o[0][0]), 32'd1);
    check("first_step_dir", 32'(dir_o[0][0]), 32'd1);
    check("first_step_ch1", 32'(val[0][15:8]), 32'd0);
    tick();
    check("first_step_one_cycle", 32'(stp_o[0][0]), 32'd0);
    set_ab(0, 0, 0, 12);

    // Bounce rejection: 1-cycle toggles, a 7-cycle pulse, then a 9-cycle pulse.
    for (int k = 0; k < 6; k++) set_ab(0, k[0] == 1'b0, 0, 1);
    set_ab(0, 0, 0, 12);
    set_ab(0, 1, 0, 7);
    set_ab(0, 0, 0, 12);
    check("bounce_no_count", 32'(val[0][7:0]), 32'd1);
    set_ab(0, 1, 0, 9);
    set_ab(0, 0, 0, 12);
    check("bounce_long_counts", 32'(val[0][7:0]), 32'd2);

    // Wrap / clamp at the top, then at the bottom.
    load = 2'b11; load_value = 8'hFF; tick(); load = '0;
    set_ab(0, 1, 0, 12);
    check("wrap_up", 32'(val[0][7:0]), 32'd0);
    check("clamp_up", 32'(val[1][7:0]), 32'd255);
    set_ab(0, 0, 1, 12);
    set_ab(0, 1, 1, 12);
    check("wrap_down", 32'(val[0][7:0]), 32'd255);
    set_ab(0, 0, 1, 12);
    set_ab(0, 0, 0, 12);
    load = 2'b11; load_value = 8'h00; tick(); load = '0;
    set_ab(0, 0, 1, 12);
    set_ab(0, 1, 1, 12);
    check("clamp_down", 32'(val[1][7:0]), 32'd0);
    set_ab(0, 0, 1, 12);
    set_ab(0, 0, 0, 12);

    // x4 forward, reverse and an illegal double change.
    load = 2'b11; load_value = 8'd10; tick(); load = '0;
    set_ab(0, 0, 1, 12); set_ab(0, 1, 1, 12); set_ab(0, 1, 0, 12); set_ab(0, 0, 0, 12);
    check("x4_forward", 32'(val[2][7:0]), 32'd14);
    set_ab(0, 1, 0, 12); set_ab(0, 1, 1, 12); set_ab(0, 0, 1, 12); set_ab(0, 0, 0, 12);
    check("x4_reverse", 32'(val[2][7:0]), 32'd10);
    set_ab(0, 1, 1, 12);
    check("x4_illegal_err", 32'(err_o[2][0]), 32'd1);
    check("x4_illegal_value", 32'(val[2][7:0]), 32'd10);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("x4_clr_err", 32'(err_o[2][0]), 32'd0);
    set_ab(0, 0, 1, 12); set_ab(0, 0, 0, 12);

    // Load on channel 1 in the cycle its step lands.
    a[1] = 1'b1;
    ticks(9);
    load = 2'b10; load_value = 8'h80; tick(); load = '0;
    check("load_prio_value", 32'(val[0][15:8]), 32'h80);
    check("load_prio_strobe", 32'(stp_o[0][1]), 32'd1);
    set_ab(1, 0, 0, 12);

    // Both channels step in the same cycle.
    a = 2'b11;
    ticks(10);
    check("concurrent_step", 32'(stp_o[0]), 32'd3);
    ticks(2);

    // Randomized Gray walk with short holds, occasional illegal jumps, loads and clears.
    for (int c = 0; c < NC; c++) begin
      gp[c] = gpos(a[c], b[c]);
      hold_cnt[c] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NC; c++) begin
        if (hold_cnt[c] == 0) begin
          int r;
          r = $urandom_range(0, 9);
          if (r < 4) gp[c] = (gp[c] + 1) % 4;
          else if (r < 8) gp[c] = (gp[c] + 3) % 4;
          else if (r == 8) gp[c] = (gp[c] + 2) % 4;
          a[c] = (gp[c] == 2) || (gp[c] == 3);
          b[c] = (gp[c] == 1) || (gp[c] == 2);
          hold_cnt[c] = $urandom_range(1, 16);
        end else begin
          hold_cnt[c]--;
        end
        load[c] = ($urandom_range(0, 31) == 0);
      end
      load_value = 8'($urandom);
      clr_err = ($urandom_range(0, 19) == 0);
      tick();
    end
    load = '0; clr_err = 1'b0;

    // Reset in the middle of a debounce: nothing may surface afterwards.
    a = '0; b = '0;
    ticks(12);
    a[0] = 1'b1;
    ticks(4);
    a[0] = 1'b0;
    pulse_reset();
    for (int k = 0; k < 20; k++) begin
      tick();
      check("post_reset_no_step", 32'(stp_o[0]), 32'd0);
    end
    check("post_reset_value", 32'(val[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_encoder_bank.md
Name: quad_encoder_bank

Overview:
- Parametrised bank of NUM_CH rotary-encoder channels. Each channel has its own debounce on the a and b inputs, a quadrature decoder with x1 or x4 resolution, and an up/down counter that either wraps or saturates.
- Drives the per-channel values consumed by the colour/PWM logic.
- Adds over the previous generation:
  - runtime preload of any channel's counter;
  - per-step strobe and direction outputs;
  - sticky illegal-transition flags.

Parameters:
- NUM_CH, 3: number of independent encoder channels.
- WIDTH, 8: counter width per channel.
- HIST_LEN, 8: debounce history length in samples (>=2).
- STEP, 1: increment/decrement amount per decoded step (1..2^WIDTH-1).
- DECODE, 1: 1 = count on rising edge of a only; 4 = count on every legal Gray transition.
- SATURATE, 0: 0 = counter wraps modulo 2^WIDTH; 1 = counter clamps at 0 and 2^WIDTH-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- a  in  NUM_CH  raw encoder A inputs, one bit per channel, asynchronous to clk.
- b  in  NUM_CH  raw encoder B inputs, one bit per channel.
- load  in  NUM_CH  per-channel preload strobe.
- load_value  in  WIDTH  value written to every channel whose load bit is high.
- clr_err  in  1  clears all err bits.
- value  out  NUM_CH*WIDTH  counters; channel i occupies bits [i*WIDTH +: WIDTH].
- step  out  NUM_CH  one-cycle strobe per decoded step.
- dir  out  NUM_CH  direction of the last step: 1 = up, 0 = down.
- err  out  NUM_CH  sticky illegal-transition flag (x4 mode only).

Behaviour:
- Clock and reset:
  - Single clock domain; all state is updated on the rising edge of clk.
  - reset is asynchronous and active-high; it is honoured mid-operation with no completion of a pending step.
- Reset values: value=0, step=0, dir=0, err=0, debounce histories=0, debounced a/b=0, previous-ab registers=0.
- Debounce (per input):
  - The raw input shifts into a HIST_LEN-bit history every cycle.
  - The registered debounced bit becomes 1 when the history is all ones, becomes 0 when it is all zeros, and otherwise holds.
  - A clean raw change is reflected in the debounced bit HIST_LEN+1 edges later.
  - Any glitch shorter than HIST_LEN cycles produces no change.
- Decoder (per channel):
  - prev_ab registers the debounced {a,b} every cycle; detection compares the current debounced {a,b} with prev_ab.
  - DECODE=1:
    - Step when a goes 0->1.
    - b=0 gives up; b=1 gives down.
    - All other transitions are ignored.
  - DECODE=4:
    - Up on 00->01, 01->11, 11->10, 10->00.
    - Down on the reverse sequence.
    - A change of both bits in one cycle is illegal: no count, err[i] set to 1.
- Counter update and strobes (same edge as prev_ab update):
  - value, step and dir update on the edge where the transition is detected.
  - Total latency from a clean raw edge to the counter update is HIST_LEN+2 edges.
  - step[i] is high for exactly one cycle per decoded step, even when the counter is clamped.
  - dir[i] updates only on steps.
- Arithmetic:
  - Computed in WIDTH+1 bits.
  - SATURATE=0: result taken modulo 2^WIDTH.
  - SATURATE=1: up clamps to 2^WIDTH-1 and down clamps to 0. Example: value=254, STEP=4, up gives 255.
- Load:
  - load[i] high sets value[i]=load_value on the next edge.
  - load has priority over a step in the same cycle; the step strobe still fires but the count is discarded.
- err:
  - Set by an illegal transition.
  - Cleared by clr_err; if set and clear occur in the same cycle, set wins.
  - Never set in DECODE=1 mode.
- Channels are fully independent; simultaneous events on different channels are all processed in the same cycle.

Test Plan:
- Reset / first step (NUM_CH=2, WIDTH=8, HIST_LEN=8, DECODE=1, STEP=1):
  - Assert reset mid-cycle, then release → value=0, step=0, err=0 immediately.
  - Hold b0=0 and raise a0 → value[7:0]=1 exactly 10 edges later; step[0] high 1 cycle; dir[0]=1; value[15:8] unchanged.
- Bounce rejection: toggle a0 every cycle for 6 cycles, then return low → no step, value unchanged. Repeat with a 7-cycle pulse → no step; with a 9-cycle high → one step.
- Wrap and saturate:
  - SATURATE=0: load 255, one up step → 0; one down step → 255.
  - SATURATE=1: load 255 + up → 255 with step pulse; load 0 + down → 0.
- x4 decode (DECODE=4):
  - Full sequence 00→01→11→10→00 with each state held 12 cycles → +4, four step pulses, dir=1.
  - Reverse sequence → −4.
  - 00→11 → value unchanged, err[0]=1; clr_err → 0.
- Load priority: load[1] with load_value=0x80 on the same cycle channel 1 decodes an up step → value[15:8]=0x80, step[1]=1.
- Concurrent channels: both channels step up in the same cycle → both counters increment together. Assert reset mid-debounce → no step occurs afterwards.
